// File: rtl/ram_b_pkg.sv
// Shared types for the byte-enable RAM access controller: size codes and FSM states.
package ram_b_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_X = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    RDATA = 2'b10,
    RESP  = 2'b11
  } state_e;

endpackage

// File: rtl/ram_b_lane.sv
// Combinational lane logic: store byte enables / replicated data, load extract and extend.
module ram_b_lane
  import ram_b_pkg::*;
(
  input  size_e              size,
  input  logic [1:0]         k,
  input  logic               is_unsigned,
  input  logic [DATA_W-1:0]  wdata,
  input  logic [DATA_W-1:0]  dout,
  output logic [3:0]         we_c,
  output logic [DATA_W-1:0]  din_c,
  output logic [DATA_W-1:0]  rdata_c
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  always_comb begin
    we_c    = 4'b0000;
    din_c   = '0;
    rdata_c = '0;
    byte_c  = 8'(dout >> {k, 3'b000});
    half_c  = k[1] ? dout[31:16] : dout[15:0];
    case (size)
      SZ_B: begin
        we_c    = 4'b0001 << k;
        din_c   = {4{wdata[7:0]}};
        rdata_c = is_unsigned ? {24'h000000, byte_c} : {{24{byte_c[7]}}, byte_c};
      end
      SZ_H: begin
        we_c    = k[1] ? 4'b1100 : 4'b0011;
        din_c   = {2{wdata[15:0]}};
        rdata_c = is_unsigned ? {16'h0000, half_c} : {{16{half_c[15]}}, half_c};
      end
      SZ_W: begin
        we_c    = 4'b1111;
        din_c   = wdata;
        rdata_c = dout;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ram_b_ctrl.sv
// LSU-side controller for a 1-cycle-latency byte-enable word RAM.
// Build option: MISALIGN_TRAP_EN turns misaligned half/word accesses into error responses.
module ram_b_ctrl
  import ram_b_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned MEM_SIZE   = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_din,
  output logic [3:0]            mem_we,
  input  logic [31:0]           mem_dout
);

  localparam logic [31:0] BYTE_SPAN = 32'(MEM_SIZE * 4);

  state_e     state;
  size_e      size_q;
  logic [1:0] k_q;
  logic       uns_q;
  logic       we_q;

  size_e       size_c;
  logic [1:0]  k_c;
  logic        mis_c;
  logic        err_c;
  size_e       lane_size_c;
  logic [1:0]  lane_k_c;
  logic        lane_uns_c;
  logic [3:0]  lane_we_c;
  logic [31:0] lane_din_c;
  logic [31:0] lane_rdata_c;

  assign req_ready = (state == IDLE);

  // Request classification and lane offset after alignment policy
  always_comb begin
    size_c = size_e'(req_size);
    k_c    = req_addr[1:0];
    mis_c  = 1'b0;
`ifdef MISALIGN_TRAP_EN
    mis_c = ((size_c == SZ_H) && req_addr[0]) || ((size_c == SZ_W) && (req_addr[1:0] != 2'b00));
`else
    if (size_c == SZ_H) k_c[0] = 1'b0;
    if (size_c == SZ_W) k_c    = 2'b00;
`endif
    err_c = (size_c == SZ_X) || (req_addr >= BYTE_SPAN) || mis_c;
  end

  // The lane block serves request-side store encoding in IDLE and load extraction later
  assign lane_size_c = (state == IDLE) ? size_c : size_q;
  assign lane_k_c    = (state == IDLE) ? k_c : k_q;
  assign lane_uns_c  = (state == IDLE) ? req_unsigned : uns_q;

  ram_b_lane u_lane (
    .size        (lane_size_c),
    .k           (lane_k_c),
    .is_unsigned (lane_uns_c),
    .wdata       (req_wdata),
    .dout        (mem_dout),
    .we_c        (lane_we_c),
    .din_c       (lane_din_c),
    .rdata_c     (lane_rdata_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      size_q    <= SZ_B;
      k_q       <= 2'b00;
      uns_q     <= 1'b0;
      we_q      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      mem_addr  <= '0;
      mem_din   <= '0;
      mem_we    <= 4'b0000;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (err_c) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              state    <= ISSUE;
              mem_addr <= req_addr[ADDR_WIDTH+1:2];
              size_q   <= size_c;
              k_q      <= k_c;
              uns_q    <= req_unsigned;
              we_q     <= req_we;
              if (req_we) begin
                mem_we  <= lane_we_c;
                mem_din <= lane_din_c;
              end
            end
          end
        end
        ISSUE: begin
          mem_we <= 4'b0000;
          if (we_q) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
          end else begin
            state <= RDATA;
          end
        end
        RDATA: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= lane_rdata_c;
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
